// File: rtl/object_bbox_tracker.sv
// rtl/object_bbox_tracker.sv - bounding-box tracker and border overlay for frame-differencing detections
//
// Purpose: accumulates the bounding box of detected pixels over each even
// (compare) frame, commits it at the odd-frame boundary, and optionally draws
// the last committed box as a border on the outgoing pixel stream.
//
// Optional feature macro: BBOX_OVERLAY_EN (defined = draw border, undefined =
// registered passthrough with identical latency).
//
// Ports:
//   iCLK, iRST                 clock, synchronous active-low reset
//   iDVAL, iObjectDetected     pixel valid and per-pixel detection flag
//   iRed/iGreen/iBlue          incoming 12-bit pixel
//   iFrame_Cont                frame counter (bit 0: 1 = odd/store, 0 = even/compare)
//   iX_Cont, iY_Cont           pixel column / row
//   oRed/oGreen/oBlue, oDVAL   registered pixel (border applied), 1-cycle latency
//   oBox_Valid                 committed box met the hit threshold
//   oX_Min/oX_Max/oY_Min/oY_Max committed box extents
//   oHit_Count                 committed hit count, saturating
//   oFrame_Done                one-cycle pulse when committed outputs update

module object_bbox_tracker #(
  parameter int          MIN_HITS = 30,
  parameter logic [11:0] BOX_R    = 12'h000,
  parameter logic [11:0] BOX_G    = 12'hFFF,
  parameter logic [11:0] BOX_B    = 12'h000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic        iObjectDetected,
  input  logic [11:0] iRed,
  input  logic [11:0] iGreen,
  input  logic [11:0] iBlue,
  input  logic [31:0] iFrame_Cont,
  input  logic [9:0]  iX_Cont,
  input  logic [8:0]  iY_Cont,
  output logic [11:0] oRed,
  output logic [11:0] oGreen,
  output logic [11:0] oBlue,
  output logic        oDVAL,
  output logic        oBox_Valid,
  output logic [9:0]  oX_Min,
  output logic [9:0]  oX_Max,
  output logic [8:0]  oY_Min,
  output logic [8:0]  oY_Max,
  output logic [19:0] oHit_Count,
  output logic        oFrame_Done
);

  typedef enum logic [1:0] {SYNC, ARMED, ACCUM, COMMIT} state_t;

  localparam logic [19:0] MIN_HITS_W = 20'(MIN_HITS);
  localparam logic [19:0] HITS_SAT   = 20'hFFFFF;

  state_t      state;
  logic        frameFF;
  logic        pendingFall;
  logic [9:0]  xMin;
  logic [9:0]  xMax;
  logic [8:0]  yMin;
  logic [8:0]  yMax;
  logic [19:0] hits;

  logic frameBit;
  logic rise;
  logic fall;
  logic detHit;
  logic isBorder;
  logic unusedFrameBits;

  assign frameBit        = iFrame_Cont[0];
  assign unusedFrameBits = ^iFrame_Cont[31:1];
  assign rise            = ~frameFF & frameBit;
  assign fall            = frameFF & ~frameBit;
  assign detHit          = iDVAL & iObjectDetected;

  // Border test against the committed registers so a box being built in the
  // current frame never disturbs the picture.
`ifdef BBOX_OVERLAY_EN
  logic xOnEdge;
  logic yOnEdge;
  logic xInside;
  logic yInside;

  always_comb begin
    xOnEdge  = (iX_Cont == oX_Min) || (iX_Cont == oX_Max);
    yOnEdge  = (iY_Cont == oY_Min) || (iY_Cont == oY_Max);
    xInside  = (iX_Cont >= oX_Min) && (iX_Cont <= oX_Max);
    yInside  = (iY_Cont >= oY_Min) && (iY_Cont <= oY_Max);
    isBorder = oBox_Valid && ((xOnEdge && yInside) || (yOnEdge && xInside));
  end
`else
  assign isBorder = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      oRed   <= 12'd0;
      oGreen <= 12'd0;
      oBlue  <= 12'd0;
      oDVAL  <= 1'b0;
    end else begin
      oDVAL <= iDVAL;
      if (isBorder) begin
        oRed   <= BOX_R;
        oGreen <= BOX_G;
        oBlue  <= BOX_B;
      end else begin
        oRed   <= iRed;
        oGreen <= iGreen;
        oBlue  <= iBlue;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state       <= SYNC;
      frameFF     <= 1'b0;
      pendingFall <= 1'b0;
      xMin        <= 10'h3FF;
      xMax        <= 10'd0;
      yMin        <= 9'h1FF;
      yMax        <= 9'd0;
      hits        <= 20'd0;
      oBox_Valid  <= 1'b0;
      oX_Min      <= 10'd0;
      oX_Max      <= 10'd0;
      oY_Min      <= 9'd0;
      oY_Max      <= 9'd0;
      oHit_Count  <= 20'd0;
      oFrame_Done <= 1'b0;
    end else begin
      frameFF     <= frameBit;
      oFrame_Done <= 1'b0;
      case (state)
        // Wait for a full odd frame so a partial even frame after reset
        // never produces a box.
        SYNC: begin
          if (rise) state <= ARMED;
        end
        ARMED: begin
          // pendingFall covers a fall that landed on the COMMIT cycle.
          if (fall || pendingFall) begin
            state       <= ACCUM;
            pendingFall <= 1'b0;
            xMin        <= 10'h3FF;
            xMax        <= 10'd0;
            yMin        <= 9'h1FF;
            yMax        <= 9'd0;
            hits        <= 20'd0;
          end
        end
        ACCUM: begin
          // The rise-cycle pixel already belongs to the odd frame.
          if (rise) begin
            state <= COMMIT;
          end else if (detHit) begin
            if (hits != HITS_SAT) hits <= hits + 20'd1;
            if (iX_Cont < xMin) xMin <= iX_Cont;
            if (iX_Cont > xMax) xMax <= iX_Cont;
            if (iY_Cont < yMin) yMin <= iY_Cont;
            if (iY_Cont > yMax) yMax <= iY_Cont;
          end
        end
        COMMIT: begin
          if (hits >= MIN_HITS_W) begin
            oBox_Valid <= 1'b1;
            oX_Min     <= xMin;
            oX_Max     <= xMax;
            oY_Min     <= yMin;
            oY_Max     <= yMax;
          end else begin
            oBox_Valid <= 1'b0;
            oX_Min     <= 10'd0;
            oX_Max     <= 10'd0;
            oY_Min     <= 9'd0;
            oY_Max     <= 9'd0;
          end
          oHit_Count  <= hits;
          oFrame_Done <= 1'b1;
          pendingFall <= fall;
          state       <= ARMED;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: doc/object_bbox_tracker.md
# object_bbox_tracker

Downstream of the odd/even frame-differencing detector. Consumes its per-pixel detection flag and pixel stream, accumulates a bounding box of detected pixels over each even (compare) frame, and commits the box at the frame boundary. Optionally draws the last committed box as a coloured border on the outgoing pixel stream toward the VGA/display path.

## Interface
Parameters:
- MIN_HITS, 30: minimum detected pixels in a frame for the committed box to be valid.
- BOX_R / BOX_G / BOX_B, 12'h000 / 12'hFFF / 12'h000: border colour.

Ports (all single clock, reset synchronous active-low):
- iCLK  in  1  clock.
- iRST  in  1  synchronous active-low reset.
- iDVAL  in  1  pixel valid from detector.
- iObjectDetected  in  1  per-pixel detection flag, qualified by iDVAL.
- iRed / iGreen / iBlue  in  12 each  pixel from detector.
- iFrame_Cont  in  32  frame counter; only bit 0 used (1 = odd/store, 0 = even/compare).
- iX_Cont  in  10  pixel column.
- iY_Cont  in  9  pixel row.
- oRed / oGreen / oBlue  out  12 each  registered pixel, border applied.
- oDVAL  out  1  iDVAL delayed 1 cycle.
- oBox_Valid  out  1  committed box is valid.
- oX_Min / oX_Max  out  10  committed box columns.
- oY_Min / oY_Max  out  9  committed box rows.
- oHit_Count  out  20  committed hit count, saturating at 20'hFFFFF.
- oFrame_Done  out  1  one-cycle pulse the cycle after commit.

## Operation
- frame_ff: register of iFrame_Cont[0]. rise = ~frame_ff & bit0; fall = frame_ff & ~bit0.
- FSM states:
  - SYNC: reset state. On rise -> ARMED. Partial even frames after reset are ignored.
  - ARMED: odd frame. On fall -> ACCUM and init accumulators: xmin=10'h3FF, ymin=9'h1FF, xmax=0, ymax=0, hits=0.
  - ACCUM: every cycle with iDVAL & iObjectDetected: hits+1 (saturating), xmin=min(xmin,iX_Cont), xmax=max, same for y. On rise -> COMMIT. The rise-cycle pixel is not accumulated.
  - COMMIT: one cycle. If hits ≥ MIN_HITS, load outputs from accumulators and set oBox_Valid=1. Otherwise oBox_Valid=0 and coords=0. oHit_Count=hits always. Pulse oFrame_Done. -> ARMED.
- Committed outputs hold until the next COMMIT.
- Comparisons are unsigned. Counter saturates, never wraps.
- Border pixel when oBox_Valid and either:
  - (x==oX_Min or x==oX_Max) and oY_Min ≤ y ≤ oY_Max; or
  - (y==oY_Min or y==oY_Max) and oX_Min ≤ x ≤ oX_Max.
  - Border pixels output BOX_R/G/B; all others pass through.
- Border test uses the committed registers, not the in-progress accumulators.

## Timing
- Reset (iRST=0 at clock edge): state SYNC, frame_ff=0, all outputs 0 (pixels, oDVAL, oBox_Valid, coords, oHit_Count, oFrame_Done). Reset mid-frame discards accumulation. Reset dominates any edge in the same cycle.
- Pixel path latency is 1 cycle. oRed/oGreen/oBlue/oDVAL at cycle n+1 correspond to inputs at cycle n.
- Commit sequence:
  - Rise seen at cycle n -> state COMMIT at n+1.
  - Committed outputs and oFrame_Done=1 visible at n+2.
  - oFrame_Done=0 at n+3.
- New box affects the overlay from the first pixel after outputs update.
- Back-to-back frame flips (rise then fall on consecutive cycles): COMMIT still completes. Fall during COMMIT is honoured next cycle via frame_ff (ARMED sees ~bit0 & frame_ff=0 → treat as fall; implementation must capture it with a pending flag).

## Configuration
- BBOX_OVERLAY_EN defined: border drawing as above.
- BBOX_OVERLAY_EN undefined: pixels pass through registered, with the same 1-cycle latency. Box tracking outputs are unaffected.

## Test plan
- Reset, then odd frame, then even frame with 40 hits spanning x 100..139, y 50..59; then rise -> oBox_Valid=1, oX_Min=100, oX_Max=139, oY_Min=50, oY_Max=59, oHit_Count=40, single oFrame_Done pulse 2 cycles after rise.
- Even frame with 29 hits -> oBox_Valid=0, coords 0, oHit_Count=29.
- Even frame before any rise after reset, with 100 hits -> no commit, oFrame_Done stays 0.
- Committed box (100,50)-(139,59), stream pixel x=100, y=55, iGreen=12'h123 -> next cycle oRed=0, oGreen=FFF, oBlue=0. Pixel x=120, y=55 -> passthrough. Without BBOX_OVERLAY_EN, both pass through.
- Assert iRST=0 mid-ACCUM after 50 hits, release, run a full odd+even frame with 35 hits at x=5..39 -> box reflects only the 35 hits.
- iObjectDetected=1 with iDVAL=0 for 1000 cycles in an even frame -> oHit_Count=0 at commit.
